// File: rtl/axis_interpolator.sv
// AXI4-Stream rate expander: each accepted sample becomes cfg_data+1 output beats,
// either held (zero-order hold) or followed by zeros (zero-stuff), tlast on the final beat.
module axis_interpolator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_mode,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast
);

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t                      state;
    logic [CNTR_WIDTH-1:0]       cntr;
    logic [CNTR_WIDTH-1:0]       cntr_inc;
    logic [CNTR_WIDTH-1:0]       cfg_q;
    logic                        mode_q;
    logic [AXIS_TDATA_WIDTH-1:0] sample_q;
    logic                        in_hs;
    logic                        out_hs;

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // a valid source holds data/last stable until that edge. Input ready opens when
    // idle or when the final beat of the current group is leaving, so groups chain
    // back-to-back without a bubble.
    assign s_axis_tready = ~areset & ((state == EMPTY) | (m_axis_tready & m_axis_tlast));
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign cntr_inc      = cntr + CNTR_WIDTH'(1);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= EMPTY;
            cntr          <= '0;
            cfg_q         <= '0;
            mode_q        <= 1'b0;
            sample_q      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (in_hs) begin
            // Config is captured only here, so mid-group changes wait for the next sample.
            state         <= EMIT;
            cntr          <= '0;
            cfg_q         <= cfg_data;
            mode_q        <= cfg_mode;
            sample_q      <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= (cfg_data == '0);
        end else if (out_hs) begin
            if (m_axis_tlast) begin
                state         <= EMPTY;
                cntr          <= '0;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tlast  <= 1'b0;
            end else begin
                // cntr < cfg_q here, so the increment cannot wrap even for all-ones cfg.
                cntr          <= cntr_inc;
                m_axis_tdata  <= mode_q ? '0 : sample_q;
                m_axis_tlast  <= (cntr_inc == cfg_q);
            end
        end
    end

endmodule

// File: tb/tb_axis_interpolator.sv
// Directed bench for axis_interpolator: per-cycle vector table plus a hand-written
// mid-group reset sequence.
module tb_axis_interpolator;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          aclk;
    logic          areset;
    logic [CW-1:0] cfg_data;
    logic          cfg_mode;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;

    axis_interpolator #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH      (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_data     (cfg_data),
        .cfg_mode     (cfg_mode),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One record per clock cycle: inputs presented during the cycle and the
    // outputs expected in that same cycle (before the next rising edge).
    typedef struct {
        int          test_id;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic [31:0] cfg;
        logic        mode;
        logic        e_v;
        logic [31:0] e_d;
        logic        e_l;
        logic        e_r;
    } vec_t;

    vec_t vec_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(int t, logic sv, logic [31:0] sd, logic mr,
                                logic [31:0] cfg, logic mode,
                                logic e_v, logic [31:0] e_d, logic e_l, logic e_r);
        vec_t v;
        v.test_id = t; v.sv = sv; v.sd = sd; v.mr = mr; v.cfg = cfg; v.mode = mode;
        v.e_v = e_v; v.e_d = e_d; v.e_l = e_l; v.e_r = e_r;
        vec_q.push_back(v);
    endfunction

    task automatic check(input string name, input int t, input int c,
                         input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s test%0d cycle%0d got=%h exp=%h", name, t, c, got, exp);
        end
    endtask

    task automatic check_outputs(input int t, input int c, input logic e_v,
                                 input logic [31:0] e_d, input logic e_l, input logic e_r);
        check("m_tvalid", t, c, 32'(m_axis_tvalid), 32'(e_v));
        check("m_tdata",  t, c, m_axis_tdata,       e_d);
        check("m_tlast",  t, c, 32'(m_axis_tlast),  32'(e_l));
        check("s_tready", t, c, 32'(s_axis_tready), 32'(e_r));
    endtask

    // driver: present inputs just after the falling edge, observe 1 ns later
    task automatic drive(input logic sv, input logic [31:0] sd, input logic mr,
                         input logic [31:0] cfg, input logic mode);
        @(negedge aclk);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        cfg_data      = cfg;
        cfg_mode      = mode;
        #1;
    endtask

    initial begin
        areset        = 1'b1;
        cfg_data      = '0;
        cfg_mode      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // 1: passthrough, tlast every beat
        add(1, 1, 32'h1, 1, 0, 0,  0, 32'h0, 0, 1);
        add(1, 1, 32'h2, 1, 0, 0,  1, 32'h1, 1, 1);
        add(1, 1, 32'h3, 1, 0, 0,  1, 32'h2, 1, 1);
        add(1, 0, 32'h0, 1, 0, 0,  1, 32'h3, 1, 1);
        add(1, 0, 32'h0, 1, 0, 0,  0, 32'h0, 0, 1);
        // 2: ratio 4 hold, back-to-back groups
        add(2, 1, 32'hA, 1, 3, 0,  0, 32'h0, 0, 1);
        add(2, 1, 32'hB, 1, 3, 0,  1, 32'hA, 0, 0);
        add(2, 1, 32'hB, 1, 3, 0,  1, 32'hA, 0, 0);
        add(2, 1, 32'hB, 1, 3, 0,  1, 32'hA, 0, 0);
        add(2, 1, 32'hB, 1, 3, 0,  1, 32'hA, 1, 1);
        add(2, 0, 32'h0, 1, 3, 0,  1, 32'hB, 0, 0);
        add(2, 0, 32'h0, 1, 3, 0,  1, 32'hB, 0, 0);
        add(2, 0, 32'h0, 1, 3, 0,  1, 32'hB, 0, 0);
        add(2, 0, 32'h0, 1, 3, 0,  1, 32'hB, 1, 1);
        add(2, 0, 32'h0, 1, 3, 0,  0, 32'h0, 0, 1);
        // 3: ratio 3 zero-stuff
        add(3, 1, 32'h5, 1, 2, 1,  0, 32'h0, 0, 1);
        add(3, 0, 32'h0, 1, 2, 1,  1, 32'h5, 0, 0);
        add(3, 0, 32'h0, 1, 2, 1,  1, 32'h0, 0, 0);
        add(3, 0, 32'h0, 1, 2, 1,  1, 32'h0, 1, 1);
        add(3, 0, 32'h0, 1, 2, 1,  0, 32'h0, 0, 1);
        // 4: backpressure 1,0,0,1,1,0,1 -> four beats, stable while stalled
        add(4, 1, 32'h7, 1, 3, 0,  0, 32'h0, 0, 1);
        add(4, 0, 32'h0, 1, 3, 0,  1, 32'h7, 0, 0);
        add(4, 0, 32'h0, 0, 3, 0,  1, 32'h7, 0, 0);
        add(4, 0, 32'h0, 0, 3, 0,  1, 32'h7, 0, 0);
        add(4, 0, 32'h0, 1, 3, 0,  1, 32'h7, 0, 0);
        add(4, 0, 32'h0, 1, 3, 0,  1, 32'h7, 0, 0);
        add(4, 0, 32'h0, 0, 3, 0,  1, 32'h7, 1, 0);
        add(4, 0, 32'h0, 1, 3, 0,  1, 32'h7, 1, 1);
        add(4, 0, 32'h0, 1, 3, 0,  0, 32'h0, 0, 1);
        // 5: cfg 3->1 during beat 2: current group 4 beats, next group 2
        add(5, 1, 32'h9,  1, 3, 0,  0, 32'h0,  0, 1);
        add(5, 0, 32'h0,  1, 3, 0,  1, 32'h9,  0, 0);
        add(5, 0, 32'h0,  1, 1, 0,  1, 32'h9,  0, 0);
        add(5, 0, 32'h0,  1, 1, 0,  1, 32'h9,  0, 0);
        add(5, 1, 32'h10, 1, 1, 0,  1, 32'h9,  1, 1);
        add(5, 0, 32'h0,  1, 1, 0,  1, 32'h10, 0, 0);
        add(5, 0, 32'h0,  1, 1, 0,  1, 32'h10, 1, 1);
        add(5, 0, 32'h0,  1, 1, 0,  0, 32'h0,  0, 1);

        // reset state
        #12;
        check_outputs(0, 0, 0, 32'h0, 0, 0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check_outputs(0, 1, 0, 32'h0, 0, 1);

        // table-driven part
        for (int i = 0; i < vec_q.size(); i++) begin
            drive(vec_q[i].sv, vec_q[i].sd, vec_q[i].mr, vec_q[i].cfg, vec_q[i].mode);
            check_outputs(vec_q[i].test_id, i, vec_q[i].e_v, vec_q[i].e_d,
                          vec_q[i].e_l, vec_q[i].e_r);
        end

        // 6: asynchronous reset in the middle of a ratio-4 group
        drive(1, 32'h33, 1, 3, 0);
        check_outputs(6, 0, 0, 32'h0, 0, 1);
        drive(0, 32'h0, 1, 3, 0);
        check_outputs(6, 1, 1, 32'h33, 0, 0);
        drive(0, 32'h0, 1, 3, 0);
        check_outputs(6, 2, 1, 32'h33, 0, 0);
        areset = 1'b1;
        #1;
        check_outputs(6, 3, 0, 32'h0, 0, 0);
        drive(1, 32'h44, 1, 3, 1);
        areset = 1'b0;
        #1;
        check_outputs(6, 4, 0, 32'h0, 0, 1);
        drive(0, 32'h0, 1, 3, 1);
        check_outputs(6, 5, 1, 32'h44, 0, 0);
        drive(0, 32'h0, 1, 3, 1);
        check_outputs(6, 6, 1, 32'h0, 0, 0);
        drive(0, 32'h0, 1, 3, 1);
        check_outputs(6, 7, 1, 32'h0, 0, 0);
        drive(0, 32'h0, 1, 3, 1);
        check_outputs(6, 8, 1, 32'h0, 1, 1);
        drive(0, 32'h0, 1, 3, 1);
        check_outputs(6, 9, 0, 32'h0, 0, 1);

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
